// File: rtl/anita3_event_header_reader_pkg.sv
//------------------------------------------------------------------------------
// Module : anita3_event_header_reader_pkg
// Brief  : Shared widths, defaults and FSM encoding for the event header reader.
//          EVHDR_CHECKSUM_EN adds the CHECKSUM state.
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

package anita3_event_header_reader_pkg;

  localparam int HDR_ADDR_BITS  = 6;
  localparam int BUF_BITS       = 2;
  localparam int NUM_WORDS_DFLT = 22;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_LOAD     = 3'd1,
    ST_ISSUE    = 3'd2,
    ST_WAIT     = 3'd3,
    ST_PRESENT  = 3'd4,
`ifdef EVHDR_CHECKSUM_EN
    ST_CHECKSUM = 3'd5,
`endif
    ST_RELEASE  = 3'd6
  } state_t;

endpackage

`default_nettype wire

// File: rtl/evhdr_queue.sv
//------------------------------------------------------------------------------
// Module : evhdr_queue
// Brief  : Synchronous FIFO of pending buffer numbers with count/full/empty.
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module evhdr_queue
  import anita3_event_header_reader_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int WIDTH = BUF_BITS,
  localparam int PW   = $clog2(DEPTH),
  localparam int CW   = $clog2(DEPTH + 1)
) (
  input  logic             clk33_i,
  input  logic             rst_n_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] din_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] dout_o,
  output logic [CW-1:0]    count_o,
  output logic             full_o,
  output logic             empty_o
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_wr_ptr;
  logic [PW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic             w_push_ok;
  logic             w_pop_ok;

  // A full queue still accepts a push when the head leaves in the same cycle.
  assign w_push_ok = push_i && (!full_o || pop_i);
  assign w_pop_ok  = pop_i && !empty_o;

  assign dout_o  = r_mem[r_rd_ptr];
  assign count_o = r_count;
  assign full_o  = (r_count == CW'(DEPTH));
  assign empty_o = (r_count == '0);

  always_ff @(posedge clk33_i) begin
    if (!rst_n_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push_ok) begin
        r_mem[r_wr_ptr] <= din_i;
        r_wr_ptr        <= r_wr_ptr + PW'(1);
      end
      if (w_pop_ok) begin
        r_rd_ptr <= r_rd_ptr + PW'(1);
      end
      case ({w_push_ok, w_pop_ok})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: rtl/anita3_event_header_reader.sv
//------------------------------------------------------------------------------
// Module : anita3_event_header_reader
// Brief  : Queues completed event buffers and streams their header words out,
//          releasing each buffer afterwards. EVHDR_CHECKSUM_EN appends a sum word.
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module anita3_event_header_reader
  import anita3_event_header_reader_pkg::*;
#(
  parameter int NUM_WORDS   = NUM_WORDS_DFLT,
  parameter int QUEUE_DEPTH = 4
) (
  input  logic                               clk33_i,
  input  logic                               rst_n_i,
  input  logic                               event_done_i,
  input  logic [BUF_BITS-1:0]                event_buffer_i,
  output logic [BUF_BITS+HDR_ADDR_BITS-1:0]  hdr_addr_o,
  output logic                               hdr_rd_o,
  input  logic [15:0]                        hdr_dat_i,
  output logic [15:0]                        out_dat_o,
  output logic                               out_valid_o,
  input  logic                               out_ready_i,
  output logic                               out_last_o,
  output logic                               release_o,
  output logic [BUF_BITS-1:0]                release_buffer_o,
  output logic [$clog2(QUEUE_DEPTH+1)-1:0]   pending_o,
  output logic                               overflow_o
);

  localparam logic [HDR_ADDR_BITS-1:0] c_last_word = HDR_ADDR_BITS'(NUM_WORDS - 1);

  state_t                             r_state;
  logic [BUF_BITS-1:0]                r_buf;
  logic [HDR_ADDR_BITS-1:0]           r_word;
  logic [BUF_BITS+HDR_ADDR_BITS-1:0]  r_hdr_addr;
  logic                               r_hdr_rd;
  logic [15:0]                        r_out_dat;
  logic                               r_out_valid;
  logic                               r_out_last;
  logic                               r_release;
  logic [BUF_BITS-1:0]                r_release_buf;
  logic                               r_overflow;
`ifdef EVHDR_CHECKSUM_EN
  logic [15:0]                        r_sum;
`endif

  logic                               w_pop;
  logic                               w_full;
  logic                               w_empty;
  logic [BUF_BITS-1:0]                w_q_buf;
  logic [$clog2(QUEUE_DEPTH+1)-1:0]   w_pending;

  assign w_pop = (r_state == ST_LOAD);

  evhdr_queue #(
    .DEPTH (QUEUE_DEPTH),
    .WIDTH (BUF_BITS)
  ) u_queue (
    .clk33_i (clk33_i),
    .rst_n_i (rst_n_i),
    .push_i  (event_done_i),
    .din_i   (event_buffer_i),
    .pop_i   (w_pop),
    .dout_o  (w_q_buf),
    .count_o (w_pending),
    .full_o  (w_full),
    .empty_o (w_empty)
  );

  // A pulse is dropped only when full and the head is not leaving this cycle.
  always_ff @(posedge clk33_i) begin
    if (!rst_n_i) begin
      r_overflow <= 1'b0;
    end else if (event_done_i && w_full && !w_pop) begin
      r_overflow <= 1'b1;
    end
  end

  always_ff @(posedge clk33_i) begin
    if (!rst_n_i) begin
      r_state       <= ST_IDLE;
      r_buf         <= '0;
      r_word        <= '0;
      r_hdr_addr    <= '0;
      r_hdr_rd      <= 1'b0;
      r_out_dat     <= '0;
      r_out_valid   <= 1'b0;
      r_out_last    <= 1'b0;
      r_release     <= 1'b0;
      r_release_buf <= '0;
`ifdef EVHDR_CHECKSUM_EN
      r_sum         <= '0;
`endif
    end else begin
      r_hdr_rd  <= 1'b0;
      r_release <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (!w_empty) r_state <= ST_LOAD;
        end
        ST_LOAD: begin
          r_buf      <= w_q_buf;
          r_word     <= '0;
          r_hdr_rd   <= 1'b1;
          r_hdr_addr <= {w_q_buf, {HDR_ADDR_BITS{1'b0}}};
`ifdef EVHDR_CHECKSUM_EN
          r_sum      <= '0;
`endif
          r_state    <= ST_ISSUE;
        end
        ST_ISSUE: begin
          r_state <= ST_WAIT;
        end
        ST_WAIT: begin
          r_out_dat   <= hdr_dat_i;
          r_out_valid <= 1'b1;
`ifdef EVHDR_CHECKSUM_EN
          r_out_last  <= 1'b0;
          r_sum       <= r_sum + hdr_dat_i;
`else
          r_out_last  <= (r_word == c_last_word);
`endif
          r_state     <= ST_PRESENT;
        end
        ST_PRESENT: begin
          if (out_ready_i) begin
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
            if (r_word != c_last_word) begin
              r_word     <= r_word + HDR_ADDR_BITS'(1);
              r_hdr_rd   <= 1'b1;
              r_hdr_addr <= {r_buf, r_word + HDR_ADDR_BITS'(1)};
              r_state    <= ST_ISSUE;
            end else begin
`ifdef EVHDR_CHECKSUM_EN
              r_out_dat   <= r_sum;
              r_out_valid <= 1'b1;
              r_out_last  <= 1'b1;
              r_state     <= ST_CHECKSUM;
`else
              r_release     <= 1'b1;
              r_release_buf <= r_buf;
              r_state       <= ST_RELEASE;
`endif
            end
          end
        end
`ifdef EVHDR_CHECKSUM_EN
        ST_CHECKSUM: begin
          if (out_ready_i) begin
            r_out_valid   <= 1'b0;
            r_out_last    <= 1'b0;
            r_release     <= 1'b1;
            r_release_buf <= r_buf;
            r_state       <= ST_RELEASE;
          end
        end
`endif
        ST_RELEASE: begin
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign hdr_addr_o       = r_hdr_addr;
  assign hdr_rd_o         = r_hdr_rd;
  assign out_dat_o        = r_out_dat;
  assign out_valid_o      = r_out_valid;
  assign out_last_o       = r_out_last;
  assign release_o        = r_release;
  assign release_buffer_o = r_release_buf;
  assign pending_o        = w_pending;
  assign overflow_o       = r_overflow;

endmodule

`default_nettype wire

// File: tb/tb_anita3_event_header_reader.sv
//------------------------------------------------------------------------------
// Module : tb_anita3_event_header_reader
// Brief  : Scoreboard bench for the event header reader (EVHDR_CHECKSUM_EN aware).
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_anita3_event_header_reader;

  localparam int NW = 22;

  logic        clk33_i = 1'b0;
  logic        rst_n_i = 1'b0;
  logic        event_done_i = 1'b0;
  logic [1:0]  event_buffer_i = '0;
  logic [7:0]  hdr_addr_o;
  logic        hdr_rd_o;
  logic [15:0] hdr_dat_i = '0;
  logic [15:0] out_dat_o;
  logic        out_valid_o;
  logic        out_ready_i = 1'b0;
  logic        out_last_o;
  logic        release_o;
  logic [1:0]  release_buffer_o;
  logic [2:0]  pending_o;
  logic        overflow_o;

  always #15 clk33_i = ~clk33_i;

  anita3_event_header_reader #(.NUM_WORDS(NW), .QUEUE_DEPTH(4)) dut (
    .clk33_i          (clk33_i),
    .rst_n_i          (rst_n_i),
    .event_done_i     (event_done_i),
    .event_buffer_i   (event_buffer_i),
    .hdr_addr_o       (hdr_addr_o),
    .hdr_rd_o         (hdr_rd_o),
    .hdr_dat_i        (hdr_dat_i),
    .out_dat_o        (out_dat_o),
    .out_valid_o      (out_valid_o),
    .out_ready_i      (out_ready_i),
    .out_last_o       (out_last_o),
    .release_o        (release_o),
    .release_buffer_o (release_buffer_o),
    .pending_o        (pending_o),
    .overflow_o       (overflow_o)
  );

  // Header RAM holding word = address, one cycle read latency.
  logic [15:0] mem [0:255];
  initial for (int i = 0; i < 256; i++) mem[i] = 16'(i);
  always @(posedge clk33_i) if (hdr_rd_o) hdr_dat_i <= mem[hdr_addr_o];

  typedef struct packed { logic [15:0] dat; logic last; } exp_t;
  exp_t       exp_q  [$];
  logic [7:0] addr_q [$];
  logic [1:0] rel_q  [$];

  int n_cmp = 0;
  int n_err = 0;
  int n_hs  = 0;
  int n_rd  = 0;
  int n_rel = 0;

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: actual %0h required %0h", name, act, req);
    end
  endfunction

  function automatic void unexpected(input string name, input logic [31:0] act);
    n_cmp++;
    n_err++;
    $display("FAIL %s: actual %0h required nothing", name, act);
  endfunction

  // Monitor: pops expectations whenever the DUT presents a transfer.
  always @(negedge clk33_i) begin
    exp_t e;
    if (rst_n_i) begin
      if (out_valid_o && out_ready_i) begin
        n_hs++;
        if (exp_q.size() == 0) unexpected("out_word", {16'h0, out_dat_o});
        else begin
          e = exp_q.pop_front();
          check("out_dat", {16'h0, out_dat_o}, {16'h0, e.dat});
          check("out_last", {31'h0, out_last_o}, {31'h0, e.last});
        end
      end
      if (hdr_rd_o) begin
        n_rd++;
        if (addr_q.size() == 0) unexpected("hdr_rd", {24'h0, hdr_addr_o});
        else check("hdr_addr", {24'h0, hdr_addr_o}, {24'h0, addr_q.pop_front()});
      end
      if (release_o) begin
        n_rel++;
        if (rel_q.size() == 0) unexpected("release", {30'h0, release_buffer_o});
        else check("release_buf", {30'h0, release_buffer_o}, {30'h0, rel_q.pop_front()});
      end
    end
  end

  task automatic tick();
    @(posedge clk33_i);
    #1;
  endtask

  task automatic pulse_done(input logic [1:0] b);
    event_buffer_i = b;
    event_done_i   = 1'b1;
    tick();
    event_done_i   = 1'b0;
  endtask

  task automatic expect_event(input logic [1:0] b);
    logic [15:0] sum;
    logic [7:0]  a;
    sum = '0;
    for (int w = 0; w < NW; w++) begin
      a = {b, 6'(w)};
      sum += mem[a];
      addr_q.push_back(a);
`ifdef EVHDR_CHECKSUM_EN
      exp_q.push_back('{dat: mem[a], last: 1'b0});
`else
      exp_q.push_back('{dat: mem[a], last: (w == NW - 1)});
`endif
    end
`ifdef EVHDR_CHECKSUM_EN
    exp_q.push_back('{dat: sum, last: 1'b1});
`endif
    rel_q.push_back(b);
  endtask

  task automatic wait_rel(input int target, input string name);
    int cyc;
    cyc = 0;
    while (n_rel < target && cyc < 3000) begin
      tick();
      cyc++;
    end
    if (n_rel < target) unexpected({name, "_timeout"}, 32'(n_rel));
  endtask

  task automatic wait_valid(input string name);
    int cyc;
    cyc = 0;
    while (!out_valid_o && cyc < 50) begin
      tick();
      cyc++;
    end
    if (!out_valid_o) unexpected({name, "_timeout"}, 32'(cyc));
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_valid"},   {31'h0, out_valid_o}, 32'h0);
    check({tag, "_last"},    {31'h0, out_last_o}, 32'h0);
    check({tag, "_release"}, {31'h0, release_o}, 32'h0);
    check({tag, "_hdr_rd"},  {31'h0, hdr_rd_o}, 32'h0);
    check({tag, "_pending"}, {29'h0, pending_o}, 32'h0);
    check({tag, "_overflow"},{31'h0, overflow_o}, 32'h0);
    check({tag, "_addr"},    {24'h0, hdr_addr_o}, 32'h0);
    check({tag, "_dat"},     {16'h0, out_dat_o}, 32'h0);
    check({tag, "_relbuf"},  {30'h0, release_buffer_o}, 32'h0);
  endtask

  initial begin
    int lat;
    int cyc;
    int rd_before;
    int hs_base;

    // Reset state
    repeat (3) tick();
    check_reset("rst");
    rst_n_i = 1'b1;
    tick();

    // Single event on buffer 2, with first-word latency
    out_ready_i = 1'b1;
    expect_event(2'd2);
    pulse_done(2'd2);
    lat = 0;
    while (!out_valid_o && lat < 20) begin
      tick();
      lat++;
    end
    check("latency", 32'(lat), 32'd4);
    wait_rel(1, "single");
    check("single_reads", 32'(n_rd), 32'd22);

    // Backpressure on word 5 of buffer 1 (address 0x45)
    expect_event(2'd1);
    pulse_done(2'd1);
    cyc = 0;
    while (!(hdr_rd_o && hdr_addr_o == 8'h45) && cyc < 100) begin
      @(negedge clk33_i);
      cyc++;
    end
    if (cyc >= 100) unexpected("bp_issue_timeout", 32'(cyc));
    out_ready_i = 1'b0;
    tick();
    tick();
    rd_before = n_rd;
    for (int i = 0; i < 10; i++) begin
      check("bp_valid", {31'h0, out_valid_o}, 32'h1);
      check("bp_dat_hold", {16'h0, out_dat_o}, 32'h0045);
      tick();
    end
    check("bp_no_extra_rd", 32'(n_rd), 32'(rd_before));
    out_ready_i = 1'b1;
    wait_rel(2, "bp");

    // Overflow: stall buffer 1 in PRESENT, then five pulses 0,1,2,3,0
    out_ready_i = 1'b0;
    expect_event(2'd1);
    pulse_done(2'd1);
    wait_valid("ovf_stall");
    for (int i = 0; i < 5; i++) begin
      if (i < 4) expect_event(2'(i));
      pulse_done(2'(i % 4));
    end
    check("ovf_pending", {29'h0, pending_o}, 32'd4);
    check("ovf_flag", {31'h0, overflow_o}, 32'h1);
    out_ready_i = 1'b1;
    wait_rel(7, "ovf");
    repeat (40) tick();
    check("ovf_drained", {29'h0, pending_o}, 32'd0);
    check("ovf_sticky", {31'h0, overflow_o}, 32'h1);
    check("ovf_rel_count", 32'(n_rel), 32'd7);

    // Reset mid-event at word 10 of buffer 3
    hs_base = n_hs;
    expect_event(2'd3);
    pulse_done(2'd3);
    cyc = 0;
    while (n_hs < hs_base + 10 && cyc < 200) begin
      tick();
      cyc++;
    end
    if (cyc >= 200) unexpected("midrst_timeout", 32'(cyc));
    rst_n_i = 1'b0;
    exp_q.delete();
    addr_q.delete();
    rel_q.delete();
    tick();
    check_reset("midrst");
    rst_n_i = 1'b1;
    repeat (80) tick();
    check("midrst_no_release", 32'(n_rel), 32'd7);

    // Push on full queue in the LOAD pop cycle is accepted without overflow
    out_ready_i = 1'b0;
    expect_event(2'd0);
    pulse_done(2'd0);
    wait_valid("sim_stall");
    for (int i = 1; i <= 4; i++) begin
      expect_event(2'(i % 4));
      pulse_done(2'(i % 4));
    end
    check("sim_full", {29'h0, pending_o}, 32'd4);
    out_ready_i = 1'b1;
    cyc = 0;
    while (!release_o && cyc < 300) begin
      @(negedge clk33_i);
      cyc++;
    end
    if (cyc >= 300) unexpected("sim_rel_timeout", 32'(cyc));
    @(posedge clk33_i);
    @(posedge clk33_i);
    #1;
    expect_event(2'd2);
    pulse_done(2'd2);
    check("sim_pending", {29'h0, pending_o}, 32'd4);
    check("sim_no_overflow", {31'h0, overflow_o}, 32'h0);
    wait_rel(13, "sim");
    repeat (10) tick();
    check("end_pending", {29'h0, pending_o}, 32'd0);
    check("end_data_left", 32'(exp_q.size()), 32'd0);
    check("end_addr_left", 32'(addr_q.size()), 32'd0);
    check("end_rel_left", 32'(rel_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
